fg_dac_write_interface: RTL and testbench

- Downstream stage of the function generator core: consumes its sample word and one-cycle output-valid strobe.
- Drives a parallel, write-strobed DAC bus: data bus, active-low WR, active-low CLR, active-low PD.
- WR pulse is configurable, with setup and hold times.
- Samples that arrive while a write is in progress go into a one-deep pending buffer. Lost samples are counted.

---
 rtl/fg_dac_write_interface.sv | 180 ++++++++++++++++++
 tb/tb_fg_dac_write_interface.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fg_dac_write_interface.sv
// rtl/fg_dac_write_interface.sv - Write-strobed parallel DAC driver with one-deep pending buffer
module fg_dac_write_interface #(
    parameter int BITWIDTH      = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int WR_LOW_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BITWIDTH-1:0] sample_i,
    input  logic                sampleValid_i,
    input  logic                outputEnable_i,
    input  logic                clearCnt_i,
    output logic [BITWIDTH-1:0] dac_data_o,
    output logic                dac_wr_n_o,
    output logic                dac_clr_n_o,
    output logic                dac_pd_n_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic [7:0]          overrunCnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Counter reload values: each phase counts down to zero inclusive.
    localparam logic [3:0] LP_SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] LP_WRITE_LD = 4'(WR_LOW_CYCLES - 1);
    localparam logic [3:0] LP_HOLD_LD  = 4'(HOLD_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [BITWIDTH-1:0]   r_data;
    logic [BITWIDTH-1:0]   w_data_next;
    logic [BITWIDTH-1:0]   r_pend_data;
    logic [BITWIDTH-1:0]   w_pend_data_next;
    logic                  r_pend_valid;
    logic                  w_pend_valid_next;
    logic                  r_wr_n;
    logic                  r_clr_n;
    logic                  r_overrun;
    logic                  w_overrun;
    logic [7:0]            r_overrun_cnt;
    logic                  w_accept;
    logic                  w_cnt_done;
    logic                  w_hold_last;

    assign w_accept    = sampleValid_i & outputEnable_i;
    assign w_cnt_done  = (r_cnt == 4'd0);
    assign w_hold_last = (r_state == ST_HOLD) && w_cnt_done;

    // Phase sequencing, phase counter reload and DAC data selection.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = w_cnt_done ? 4'd0 : (r_cnt - 4'd1);
        w_data_next  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SETUP;
                    w_cnt_next   = LP_SETUP_LD;
                    w_data_next  = sample_i;
                end
            end
            ST_SETUP: begin
                if (w_cnt_done) begin
                    w_next_state = ST_WRITE;
                    w_cnt_next   = LP_WRITE_LD;
                end
            end
            ST_WRITE: begin
                if (w_cnt_done) begin
                    w_next_state = ST_HOLD;
                    w_cnt_next   = LP_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_done) begin
                    // The older pending sample always goes out before a fresh one.
                    if (r_pend_valid) begin
                        w_next_state = ST_SETUP;
                        w_cnt_next   = LP_SETUP_LD;
                        w_data_next  = r_pend_data;
                    end else if (w_accept) begin
                        w_next_state = ST_SETUP;
                        w_cnt_next   = LP_SETUP_LD;
                        w_data_next  = sample_i;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Pending buffer: absorbs samples arriving mid-write, newest wins on collision.
    always_comb begin
        w_pend_data_next  = r_pend_data;
        w_pend_valid_next = r_pend_valid;
        w_overrun         = 1'b0;
        if (w_accept && (r_state != ST_IDLE)) begin
            if (w_hold_last) begin
                // Pending drains into the data bus this edge, so a refill is not an overrun.
                if (r_pend_valid) begin
                    w_pend_data_next = sample_i;
                end
            end else begin
                w_overrun         = r_pend_valid;
                w_pend_data_next  = sample_i;
                w_pend_valid_next = 1'b1;
            end
        end else if (w_hold_last && r_pend_valid) begin
            w_pend_valid_next = 1'b0;
        end
    end

    // State, counter, data bus, pending buffer and registered write strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_data       <= '0;
            r_pend_data  <= '0;
            r_pend_valid <= 1'b0;
            r_wr_n       <= 1'b1;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_data       <= w_data_next;
            r_pend_data  <= w_pend_data_next;
            r_pend_valid <= w_pend_valid_next;
            r_wr_n       <= (w_next_state != ST_WRITE);
            r_overrun    <= w_overrun;
        end
    end

    // Saturating overrun counter; an overrun coinciding with a clear counts as the first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_overrun) begin
            if (clearCnt_i) begin
                r_overrun_cnt <= 8'd1;
            end else if (r_overrun_cnt != 8'hFF) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end else if (clearCnt_i) begin
            r_overrun_cnt <= 8'd0;
        end
    end

    // DAC clear follows reset asynchronously and releases on the first clock after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clr_n <= 1'b0;
        end else begin
            r_clr_n <= 1'b1;
        end
    end

    assign dac_data_o   = r_data;
    assign dac_wr_n_o   = r_wr_n;
    assign dac_clr_n_o  = r_clr_n;
    assign dac_pd_n_o   = 1'b1;
    assign busy_o       = (r_state != ST_IDLE);
    assign overrun_o    = r_overrun;
    assign overrunCnt_o = r_overrun_cnt;

endmodule

// File: tb/tb_fg_dac_write_interface.sv
// tb/tb_fg_dac_write_interface.sv - Self-checking bench for fg_dac_write_interface
module tb_fg_dac_write_interface;

    localparam int BW = 8;
    localparam int S  = 1;
    localparam int W  = 2;
    localparam int H  = 1;
    localparam int P  = S + W + H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] sample = '0;
    logic          valid = 1'b0;
    logic          oe = 1'b1;
    logic          clr_cnt = 1'b0;
    logic [BW-1:0] dac_data;
    logic          dac_wr_n;
    logic          dac_clr_n;
    logic          dac_pd_n;
    logic          busy;
    logic          overrun;
    logic [7:0]    overrun_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int wr_falls = 0;

    fg_dac_write_interface #(
        .BITWIDTH(BW), .SETUP_CYCLES(S), .WR_LOW_CYCLES(W), .HOLD_CYCLES(H)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sample_i(sample), .sampleValid_i(valid),
        .outputEnable_i(oe), .clearCnt_i(clr_cnt), .dac_data_o(dac_data),
        .dac_wr_n_o(dac_wr_n), .dac_clr_n_o(dac_clr_n), .dac_pd_n_o(dac_pd_n),
        .busy_o(busy), .overrun_o(overrun), .overrunCnt_o(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a write is a window of P cycles indexed by m_pos.
    logic          m_busy;
    int            m_pos;
    logic          m_pv;
    logic [BW-1:0] m_pd;
    logic [BW-1:0] m_data;
    logic [7:0]    m_cnt;
    logic          m_ovr;
    logic          m_clr_n;

    always @(posedge clk or posedge rst) begin
        logic a;
        if (rst) begin
            m_busy = 0; m_pos = 0; m_pv = 0; m_pd = '0; m_data = '0;
            m_cnt = 0; m_ovr = 0; m_clr_n = 0;
        end else begin
            a = valid && oe;
            m_ovr = 0;
            m_clr_n = 1;
            if (!m_busy) begin
                if (a) begin m_data = sample; m_busy = 1; m_pos = 0; end
            end else if (m_pos == P - 1) begin
                if (m_pv) begin
                    m_data = m_pd; m_pos = 0;
                    if (a) m_pd = sample; else m_pv = 0;
                end else if (a) begin
                    m_data = sample; m_pos = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_pos = m_pos + 1;
                if (a) begin
                    if (m_pv) m_ovr = 1;
                    m_pd = sample; m_pv = 1;
                end
            end
            if (m_ovr) m_cnt = clr_cnt ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
            else if (clr_cnt) m_cnt = 0;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("data", dac_data, m_data);
        chk("wr_n", dac_wr_n, !(m_busy && m_pos >= S && m_pos < S + W));
        chk("busy", busy, m_busy);
        chk("overrun", overrun, m_ovr);
        chk("overrun_cnt", overrun_cnt, m_cnt);
        chk("clr_n", dac_clr_n, m_clr_n);
        chk("pd_n", dac_pd_n, 1'b1);
    end

    always @(negedge dac_wr_n) wr_falls++;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe(input logic [BW-1:0] s);
        sample = s; valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int falls0;
        @(negedge clk);
        repeat (2) step();
        // Reset state
        chk("rst_wr_n", dac_wr_n, 1'b1);
        chk("rst_clr_n", dac_clr_n, 1'b0);
        chk("rst_data", dac_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        chk("clr_n_release", dac_clr_n, 1'b1);

        // 1: single write of 0xA5
        strobe(8'hA5);
        chk("t1_data_T1", dac_data, 8'hA5);
        chk("t1_wr_T1", dac_wr_n, 1'b1);
        step(); chk("t1_wr_T2", dac_wr_n, 1'b0);
        step(); chk("t1_wr_T3", dac_wr_n, 1'b0);
        step(); chk("t1_wr_T4", dac_wr_n, 1'b1); chk("t1_busy_T4", busy, 1'b1);
        step(); chk("t1_busy_T5", busy, 1'b0);

        // 2: two strobes two cycles apart, back-to-back writes
        strobe(8'h11);
        step();
        strobe(8'h22);
        step(); chk("t2_data_T4", dac_data, 8'h11); chk("t2_busy_T4", busy, 1'b1);
        step(); chk("t2_data_T5", dac_data, 8'h22); chk("t2_busy_T5", busy, 1'b1);
        repeat (6) step();
        chk("t2_cnt", overrun_cnt, 8'd0);

        // 3: three consecutive strobes, middle one lost
        falls0 = wr_falls;
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        chk("t3_overrun_pulse", overrun, 1'b1);
        repeat (10) step();
        chk("t3_cnt", overrun_cnt, 8'd1);
        chk("t3_last_data", dac_data, 8'h03);
        chk("t3_writes", wr_falls - falls0, 2);

        // 4: continuous strobing saturates the counter, then clear with overrun
        valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            sample = 8'(i);
            step();
        end
        chk("t4_saturated", overrun_cnt, 8'hFF);
        for (int k = 0; k < 20 && !(m_busy && m_pos == 1 && m_pv); k++) step();
        chk("t4_overrun_slot_found", (m_busy && m_pos == 1 && m_pv), 1'b1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t4_clear_with_overrun", overrun_cnt, 8'd1);
        valid = 1'b0;
        repeat (10) step();

        // 5: reset asserted during WRITE
        strobe(8'h77);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_wr_async", dac_wr_n, 1'b1);
        chk("t5_clr_async", dac_clr_n, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        falls0 = wr_falls;
        repeat (8) step();
        chk("t5_data_cleared", dac_data, 8'h00);
        chk("t5_no_stale_write", wr_falls - falls0, 0);

        // 6: output disable keeps the pending sample but ignores new strobes
        falls0 = wr_falls;
        strobe(8'h31);
        strobe(8'h32);
        oe = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample = 8'h40 + 8'(i);
            step();
        end
        valid = 1'b0;
        chk("t6_writes", wr_falls - falls0, 2);
        chk("t6_data", dac_data, 8'h32);
        chk("t6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
